// File: rtl/dataflow_stream_vec.sv
// dataflow_stream_vec: multi-lane loop-index generator. One init handshake
// captures start/step/bound plus the step/condition config; each output beat
// then carries LANES consecutive indices with per-lane continue flags.
module dataflow_stream_vec #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WIDTH-1:0]       start_data,
    input  logic                   step_valid,
    output logic                   step_ready,
    input  logic [WIDTH-1:0]       step_data,
    input  logic                   bound_valid,
    output logic                   bound_ready,
    input  logic [WIDTH-1:0]       bound_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_index,
    output logic [LANES-1:0]       out_cont,
    output logic [LANES-1:0]       out_lane_mask,
    output logic                   out_last,
    input  logic [4:0]             cfg_cont_cond_sel,
    input  logic                   cfg_unsigned,
    input  logic [2:0]             cfg_step_op,
    output logic                   error_valid,
    output logic [15:0]            error_code
);
    // Error codes shared with fabric_common.svh.
    localparam logic [15:0] CFG_PE_STREAM_CONT_COND_ONEHOT = 16'h0101;
    localparam logic [15:0] CFG_PE_STREAM_STEP_OP_INVALID  = 16'h0102;
    localparam logic [15:0] RT_DATAFLOW_STREAM_ZERO_STEP   = 16'h0201;

    typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} state_t;

    // Stream configuration frozen at init so live config edits cannot disturb it.
    typedef struct packed {
        logic [4:0] cond_sel;
        logic       is_unsigned;
        logic [2:0] step_op;
    } cfg_t;

    state_t                        state, state_nxt;
    cfg_t                          cfg_q;
    logic [WIDTH-1:0]              cur_q, step_q, bound_q;
    logic [LANES-1:0][WIDTH-1:0]   lane_v;
    logic [LANES-1:0]              raw_cont, mask;
    logic [WIDTH-1:0]              cur_adv;
    logic                          init_fire, beat_fire;

    // Single application of the step operation, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] s,
                                                 input logic [2:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = v + s;
            3'd1:    r = v - s;
            3'd2:    r = v * s;
            3'd3:    r = (s == '0) ? '1 : (v / s);
            3'd4:    r = (s >= WIDTH'(WIDTH)) ? '0 : (v << s);
            3'd5:    r = (s >= WIDTH'(WIDTH)) ? '0 : (v >> s);
            default: r = v;
        endcase
        return r;
    endfunction

    // Continue condition built from one less-than and one equality compare.
    function automatic logic cond_fn(input logic [WIDTH-1:0] v,
                                     input logic [WIDTH-1:0] b,
                                     input logic [4:0]       sel,
                                     input logic             uns);
        logic lt, eq;
        lt = uns ? (v < b) : ($signed(v) < $signed(b));
        eq = (v == b);
        return (sel[0] & lt) | (sel[1] & (lt | eq)) | (sel[2] & ~(lt | eq)) |
               (sel[3] & ~lt) | (sel[4] & ~eq);
    endfunction

    // Lane chain: each lane steps the previous lane's value.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] v, nxt;
        if (k == 0) begin : g_head
            assign v = cur_q;
        end else begin : g_tail
            assign v = g_lane[k-1].nxt;
        end
        assign nxt         = step_fn(v, step_q, cfg_q.step_op);
        assign lane_v[k]   = v;
        assign raw_cont[k] = cond_fn(v, bound_q, cfg_q.cond_sel, cfg_q.is_unsigned);
    end

    assign cur_adv   = g_lane[LANES-1].nxt;
    assign init_fire = (state == IDLE) & start_valid & step_valid & bound_valid;
    assign beat_fire = out_valid & out_ready;

    // Lane k is live only while every earlier lane still continues.
    always_comb begin
        logic run;
        mask = '0;
        run  = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            mask[k] = run;
            run     = run & raw_cont[k];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: start on init, stop once the final beat is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_fire) state_nxt = RUNNING;
            RUNNING: if (beat_fire && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: join readies in IDLE, masked lane data in RUNNING, zeros otherwise.
    always_comb begin
        start_ready   = 1'b0;
        step_ready    = 1'b0;
        bound_ready   = 1'b0;
        out_valid     = 1'b0;
        out_index     = '0;
        out_cont      = '0;
        out_lane_mask = '0;
        out_last      = 1'b0;
        case (state)
            IDLE: begin
                start_ready = step_valid & bound_valid;
                step_ready  = start_valid & bound_valid;
                bound_ready = start_valid & step_valid;
            end
            RUNNING: begin
                out_valid     = 1'b1;
                out_lane_mask = mask;
                out_last      = |(mask & ~raw_cont);
                for (int k = 0; k < LANES; k++) begin
                    if (mask[k]) begin
                        out_index[k*WIDTH +: WIDTH] = lane_v[k];
                        out_cont[k]                 = raw_cont[k];
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath: latch the stream on init, advance LANES steps per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q   <= '0;
            step_q  <= '0;
            bound_q <= '0;
            cfg_q   <= '0;
        end else if (init_fire) begin
            cur_q   <= start_data;
            step_q  <= step_data;
            bound_q <= bound_data;
            cfg_q   <= '{cond_sel: cfg_cont_cond_sel, is_unsigned: cfg_unsigned,
                         step_op: cfg_step_op};
        end else if (beat_fire && !out_last) begin
            cur_q <= cur_adv;
        end
    end

    // Sticky first-error capture; config errors outrank the runtime check.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_valid <= 1'b0;
            error_code  <= '0;
        end else if (!error_valid) begin
            if (!$onehot(cfg_cont_cond_sel)) begin
                error_valid <= 1'b1;
                error_code  <= CFG_PE_STREAM_CONT_COND_ONEHOT;
            end else if (cfg_step_op > 3'd5) begin
                error_valid <= 1'b1;
                error_code  <= CFG_PE_STREAM_STEP_OP_INVALID;
            end else if (state == RUNNING && step_q == '0) begin
                error_valid <= 1'b1;
                error_code  <= RT_DATAFLOW_STREAM_ZERO_STEP;
            end
        end
    end

endmodule

// File: tb/tb_dataflow_stream_vec.sv
// Bench for dataflow_stream_vec: streams are expanded by a sequence model
// into expected beats; one negedge process compares every cycle.
module tb_dataflow_stream_vec;
    localparam int W = 8;
    localparam int L = 4;
    localparam logic [15:0] E_ONEHOT = 16'h0101;
    localparam logic [15:0] E_STEPOP = 16'h0102;
    localparam logic [15:0] E_ZERO   = 16'h0201;
    localparam logic [4:0]  C_SLT = 5'b00001, C_SLE = 5'b00010, C_SGT = 5'b00100,
                            C_SGE = 5'b01000, C_NE  = 5'b10000;

    typedef struct {
        logic [L*W-1:0] idx;
        logic [L-1:0]   mask;
        logic [L-1:0]   cont;
        logic           last;
    } beat_t;

    beat_t eq[$];
    int    tests = 0;
    int    fails = 0;

    logic           clk, rst;
    logic           start_valid, start_ready, step_valid, step_ready, bound_valid, bound_ready;
    logic [W-1:0]   start_data, step_data, bound_data;
    logic           out_valid, out_ready, out_last;
    logic [L*W-1:0] out_index;
    logic [L-1:0]   out_cont, out_lane_mask;
    logic [4:0]     cfg_cont_cond_sel;
    logic           cfg_unsigned;
    logic [2:0]     cfg_step_op;
    logic           error_valid;
    logic [15:0]    error_code;

    dataflow_stream_vec #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
        .step_valid(step_valid), .step_ready(step_ready), .step_data(step_data),
        .bound_valid(bound_valid), .bound_ready(bound_ready), .bound_data(bound_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_cont(out_cont), .out_lane_mask(out_lane_mask), .out_last(out_last),
        .cfg_cont_cond_sel(cfg_cont_cond_sel), .cfg_unsigned(cfg_unsigned),
        .cfg_step_op(cfg_step_op), .error_valid(error_valid), .error_code(error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] opf(input logic [W-1:0] v, input logic [W-1:0] s,
                                         input logic [2:0] op);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = v + s;
            3'd1:    r = v - s;
            3'd2:    r = v * s;
            3'd3:    r = (s == 8'd0) ? 8'hff : v / s;
            3'd4:    r = (s >= 8'd8) ? 8'd0 : v << s;
            default: r = (s >= 8'd8) ? 8'd0 : v >> s;
        endcase
        return r;
    endfunction

    function automatic bit cnd(input logic [W-1:0] v, input logic [W-1:0] b,
                               input logic [4:0] sel, input bit uns);
        int a, c;
        a = uns ? int'(v) : int'($signed(v));
        c = uns ? int'(b) : int'($signed(b));
        case (sel)
            C_SLT:   return a < c;
            C_SLE:   return a <= c;
            C_SGT:   return a > c;
            C_SGE:   return a >= c;
            C_NE:    return v != b;
            default: return 1'b0;
        endcase
    endfunction

    // Expand the do-while index sequence, then cut it into LANES-wide beats.
    function automatic bit build(input logic [W-1:0] s, input logic [W-1:0] st,
                                 input logic [W-1:0] b, input logic [2:0] op,
                                 input logic [4:0] sel, input bit uns, input int maxb);
        logic [W-1:0] seq[$];
        bit           cs[$];
        logic [W-1:0] v;
        bit           term, c;
        beat_t        bt;
        int           nb, p;
        v = s; term = 1'b0;
        for (int i = 0; i < maxb * L; i++) begin
            c = cnd(v, b, sel, uns);
            seq.push_back(v);
            cs.push_back(c);
            if (!c) begin term = 1'b1; break; end
            v = opf(v, st, op);
        end
        nb = (seq.size() + L - 1) / L;
        for (int bi = 0; bi < nb; bi++) begin
            bt.idx = '0; bt.mask = '0; bt.cont = '0; bt.last = 1'b0;
            for (int k = 0; k < L; k++) begin
                p = bi * L + k;
                if (p < seq.size()) begin
                    bt.mask[k]          = 1'b1;
                    bt.idx[k*W +: W]    = seq[p];
                    bt.cont[k]          = cs[p];
                    if (!cs[p]) bt.last = 1'b1;
                end
            end
            eq.push_back(bt);
        end
        return term;
    endfunction

    task automatic pin(input string name, input int bi, input logic [31:0] idx,
                       input logic [3:0] mask, input logic [3:0] cont, input logic last);
        if (bi >= eq.size()) chk({name, "_missing"}, 64'(eq.size()), 64'(bi + 1));
        else chk(name, 64'({eq[bi].idx, eq[bi].mask, eq[bi].cont, eq[bi].last}),
                 64'({idx, mask, cont, last}));
    endtask

    function automatic bit pick(input int hold, input int c);
        return (hold >= 0) ? (c >= hold) : ($urandom_range(0, 3) != 0);
    endfunction

    // Per-cycle comparison of the output channel against the expected beats.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (eq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: out_valid=1 index=%0h, no beat expected", out_index);
                end else begin
                    chk("beat", 64'({out_index, out_lane_mask, out_cont, out_last}),
                        64'({eq[0].idx, eq[0].mask, eq[0].cont, eq[0].last}));
                    if (out_ready) void'(eq.pop_front());
                end
            end else begin
                chk("idle_zero", 64'({out_index, out_lane_mask, out_cont, out_last}), 64'(0));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; eq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic kick(input logic [W-1:0] s, input logic [W-1:0] st, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [4:0] sel, input bit uns);
        @(posedge clk); #1;
        start_data = s; step_data = st; bound_data = b;
        cfg_step_op = op; cfg_cont_cond_sel = sel; cfg_unsigned = uns;
        start_valid = 1'b1; step_valid = 1'b1; bound_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("init_ready", 64'({start_ready, step_ready, bound_ready}), 64'(3'b111));
        @(posedge clk); #1;
        start_valid = 1'b0; step_valid = 1'b0; bound_valid = 1'b0;
        start_data = 8'($urandom); step_data = 8'($urandom); bound_data = 8'($urandom);
        cfg_step_op = 3'($urandom_range(0, 5));
        cfg_cont_cond_sel = 5'(1 << $urandom_range(0, 4));
        cfg_unsigned = 1'($urandom);
    endtask

    task automatic run_stream(input logic [W-1:0] s, input logic [W-1:0] st, input logic [W-1:0] b,
                              input logic [2:0] op, input logic [4:0] sel, input bit uns,
                              input int hold, input int maxb);
        bit term, to;
        int cyc;
        term = build(s, st, b, op, sel, uns, maxb);
        kick(s, st, b, op, sel, uns);
        out_ready = pick(hold, 0);
        @(negedge clk);
        chk("first_beat_valid", 64'(out_valid), 64'(1));
        cyc = 0; to = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            if (eq.size() == 0) break;
            cyc++;
            if (cyc > 400) begin
                to = 1'b1; tests++; fails++;
                $display("FAIL stream_timeout: %0d beats outstanding after %0d cycles", eq.size(), cyc);
                break;
            end
            out_ready = pick(hold, cyc);
        end
        out_ready = 1'b0;
        if (!term || to) begin
            rst = 1'b1; eq.delete();
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        start_valid = 1'b0; step_valid = 1'b0; bound_valid = 1'b0;
        start_data = '0; step_data = '0; bound_data = '0;
        cfg_cont_cond_sel = C_SLT; cfg_unsigned = 1'b0; cfg_step_op = 3'd0;

        // Hand-computed expectations pin the sequence model.
        void'(build(8'd0, 8'd1, 8'd6, 3'd0, C_SLT, 1'b0, 8));
        pin("model_add_b1", 0, 32'h03020100, 4'b1111, 4'b1111, 1'b0);
        pin("model_add_b2", 1, 32'h00060504, 4'b0111, 4'b0011, 1'b1);
        eq.delete();
        void'(build(8'd10, 8'd1, 8'd5, 3'd0, C_SLT, 1'b0, 8));
        pin("model_false_start", 0, 32'h0000000a, 4'b0001, 4'b0000, 1'b1);
        eq.delete();
        void'(build(8'd1, 8'd2, 8'd20, 3'd2, C_SLT, 1'b1, 8));
        pin("model_mul_b1", 0, 32'h08040201, 4'b1111, 4'b1111, 1'b0);
        pin("model_mul_b2", 1, 32'h00002010, 4'b0011, 4'b0001, 1'b1);
        eq.delete();
        void'(build(8'd3, 8'd1, 8'd0, 3'd1, C_SGT, 1'b0, 8));
        pin("model_sub", 0, 32'h00010203, 4'b1111, 4'b0111, 1'b1);
        eq.delete();
        void'(build(8'd100, 8'd0, 8'd255, 3'd3, C_NE, 1'b0, 8));
        pin("model_div0", 0, 32'h0000ff64, 4'b0011, 4'b0001, 1'b1);
        eq.delete();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_readies", 64'({start_ready, step_ready, bound_ready}), 64'(0));
        chk("rst_outputs", 64'({out_index, out_lane_mask, out_cont, out_last}), 64'(0));
        chk("rst_error", 64'({error_valid, error_code}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed streams.
        run_stream(8'd0,  8'd1, 8'd6,  3'd0, C_SLT, 1'b0, 0, 8);
        run_stream(8'd10, 8'd1, 8'd5,  3'd0, C_SLT, 1'b0, 0, 8);
        run_stream(8'd1,  8'd2, 8'd20, 3'd2, C_SLT, 1'b1, -1, 8);
        run_stream(8'd3,  8'd1, 8'd0,  3'd1, C_SGT, 1'b0, 3, 8);
        run_stream(8'd250, 8'd1, 8'd2, 3'd0, C_SLT, 1'b0, -1, 8);
        run_stream(8'd250, 8'd1, 8'd2, 3'd0, C_SLT, 1'b1, -1, 8);

        // Reset during the second beat, then the same stream again from scratch.
        void'(build(8'd0, 8'd1, 8'd6, 3'd0, C_SLT, 1'b0, 8));
        kick(8'd0, 8'd1, 8'd6, 3'd0, C_SLT, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_beat1_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1; eq.delete(); out_ready = 1'b0;
        start_valid = 1'b1; step_valid = 1'b1; bound_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_join", 64'({start_ready, step_ready, bound_ready}), 64'(3'b001));
        @(posedge clk); #1;
        start_valid = 1'b0; step_valid = 1'b0;
        run_stream(8'd0, 8'd1, 8'd6, 3'd0, C_SLT, 1'b0, 0, 8);

        // Randomized streams with random backpressure.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            logic [W-1:0] st;
            op = 3'($urandom_range(0, 5));
            st = (op >= 3'd4) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            run_stream(8'($urandom), st, 8'($urandom), op, 5'(1 << $urandom_range(0, 4)),
                       1'($urandom), -1, 6);
        end

        // Configuration errors: registered, sticky, first wins.
        do_reset();
        chk("err_clear", 64'({error_valid, error_code}), 64'(0));
        cfg_cont_cond_sel = 5'b00011;
        @(negedge clk);
        chk("err_onehot_not_yet", 64'(error_valid), 64'(0));
        @(posedge clk); #1;
        cfg_cont_cond_sel = C_SLT; cfg_step_op = 3'd7;
        @(negedge clk);
        chk("err_onehot", 64'({error_valid, error_code}), 64'({1'b1, E_ONEHOT}));
        @(posedge clk); #1;
        cfg_step_op = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("err_onehot_sticky", 64'({error_valid, error_code}), 64'({1'b1, E_ONEHOT}));
        do_reset();
        chk("err_rst_clears", 64'({error_valid, error_code}), 64'(0));
        cfg_step_op = 3'd6;
        @(posedge clk); #1;
        cfg_step_op = 3'd0;
        @(negedge clk);
        chk("err_step_op", 64'({error_valid, error_code}), 64'({1'b1, E_STEPOP}));
        do_reset();
        cfg_cont_cond_sel = 5'b00000; cfg_step_op = 3'd7;
        @(posedge clk); #1;
        cfg_cont_cond_sel = C_SLT; cfg_step_op = 3'd0;
        @(negedge clk);
        chk("err_priority", 64'({error_valid, error_code}), 64'({1'b1, E_ONEHOT}));

        // Runtime zero-step error with div by zero producing all-ones.
        do_reset();
        run_stream(8'd100, 8'd0, 8'd255, 3'd3, C_NE, 1'b0, 0, 8);
        chk("err_zero_step", 64'({error_valid, error_code}), 64'({1'b1, E_ZERO}));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dataflow_stream_vec.md
# dataflow_stream_vec

Multi-lane, runtime-configurable successor to the single-lane dataflow stream generator. It captures start, step and bound in one handshake, then emits LANES consecutive loop indices per output beat, each with its own will-continue flag and a lane-valid mask. Step operation and signed/unsigned comparison are runtime configuration rather than elaboration parameters. It sits in the dataflow PE library and feeds vectorised loop bodies where one index per cycle is the throughput limit.

## Interface
Parameters:
- WIDTH, 32, index/step/bound width (>= 2)
- LANES, 4, indices per output beat (1..8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_valid / start_ready / start_data  in/out/in  1/1/WIDTH  start value
- step_valid / step_ready / step_data  in/out/in  1/1/WIDTH  step value
- bound_valid / bound_ready / bound_data  in/out/in  1/1/WIDTH  bound value
- out_valid  out  1  beat valid
- out_ready  in  1  beat accepted
- out_index  out  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- out_cont  out  LANES  per-lane will-continue flag
- out_lane_mask  out  LANES  lanes carrying a real index; contiguous from lane 0
- out_last  out  1  final beat of the stream
- cfg_cont_cond_sel  in  5  one-hot {ne, sge, sgt, sle, slt}, bits 4..0
- cfg_unsigned  in  1  comparisons 0-3 use unsigned ordering when 1
- cfg_step_op  in  3  0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr; 6-7 invalid
- error_valid  out  1  sticky error flag
- error_code  out  16  first error code

## Operation
- States: IDLE, RUNNING. Reset: IDLE, all registers 0; out_valid=0, out_index/out_cont/out_lane_mask/out_last=0, error_valid=0, error_code=0; all *_ready=0.
- IDLE: each ready = other two valids (join); init fires when all three valids are high. It latches start->cur, step, bound, cfg_cont_cond_sel, cfg_step_op, cfg_unsigned, then goes to RUNNING. Config changes during RUNNING have no effect on that stream.
- Lane values: v0=cur, v(k+1)=op(vk, step). All arithmetic is modulo 2^WIDTH.
  - div: unsigned; step 0 gives all-ones.
  - shl/shr: logical; shift amount >= WIDTH gives 0.
- out_cont[k] = cond(vk, bound) using the latched condition and signedness.
- out_lane_mask[k] = 1 iff out_cont[j]=1 for all j<k. Lane 0 is always valid. Lanes with mask=0 drive index 0 and cont 0.
- out_last = 1 iff some masked lane has cont=0.
- On out_valid && out_ready:
  - out_last=1: go to IDLE.
  - otherwise: cur <= op applied LANES times (i.e. op(v(LANES-1), step)).
- Stream semantics are do-while: the first index failing the condition is still emitted, with cont=0.
- Errors (sticky, first one wins; in the same cycle a cfg error outranks a runtime error):
  - CFG_PE_STREAM_CONT_COND_ONEHOT: live cfg_cont_cond_sel not one-hot, checked every cycle.
  - CFG_PE_STREAM_STEP_OP_INVALID: live cfg_step_op > 5, checked every cycle. This is a new code to be added to fabric_common.svh.
  - RT_DATAFLOW_STREAM_ZERO_STEP: RUNNING with latched step == 0.
- Errors do not stall the datapath.

## Timing
- Init handshake in cycle N; first beat valid in cycle N+1. No ready is asserted in RUNNING, so there is no back-to-back init.
- One beat per cycle while out_ready=1. Under backpressure, out_index/out_cont/out_lane_mask/out_last are held stable.
- After the last beat is accepted in cycle M: IDLE in M+1, input readies may rise in M+1, and the next stream's first beat is no earlier than M+2.
- rst asserted mid-stream: next edge returns to IDLE, out_valid=0 and errors clear. Any partially emitted stream is abandoned.
- Error flag registers one cycle after the offending condition.
- LANES=1 behaves exactly like the single-lane generator, with out_last = ~out_cont[0].

## Test plan
- WIDTH=8, LANES=4, add, slt signed; start 0, step 1, bound 6:
  - beat1: indices 0,1,2,3, mask 1111, cont 1111, last 0.
  - beat2: indices 4,5,6,0, mask 0111, cont 0011, last 1.
  - Then IDLE.
- Condition false at start: start 10, step 1, bound 5, slt: single beat, lane0=10, mask 0001, cont 0000, last 1.
- mul, slt unsigned; start 1, step 2, bound 20:
  - beat1: 1,2,4,8, cont 1111.
  - beat2: 16,32, mask 0011, cont 0001, last 1.
- sub, sgt; start 3, step 1, bound 0: one beat 3,2,1,0, mask 1111, cont 0111, last 1. Also hold out_ready low for 3 cycles mid-beat: outputs unchanged until accepted.
- Errors:
  - cfg_cont_cond_sel=00011: error_valid=1 with CFG_PE_STREAM_CONT_COND_ONEHOT next cycle, and it stays set.
  - Separate run, div with step 0: RT_DATAFLOW_STREAM_ZERO_STEP, with lane values all-ones after lane 0.
- Assert rst during beat 2 of the first scenario: next cycle out_valid=0 and readies follow IDLE join. A fresh stream then produces the first-scenario results exactly.
